// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter and its producer FIFOs.
package cdb_pkg;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  // One broadcast lane as seen by the snooping units.
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_lane_t;

  // Width needed to index n items. Never returns zero, so a single item still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Shallow per-producer result FIFO with an explicit occupancy count.
// The count removes any full/empty ambiguity when the read and write pointers are equal.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int W     = CDB_TAG_W + CDB_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO never accepts a push, even if it is being popped in the same cycle.
  assign do_push = rdy_i & ~flush_i & push_i & ~full_o;
  assign do_pop  = rdy_i & ~flush_i & pop_i & ~empty_o;

  // Storage is only written on an accepted push, so it does not need a reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and count bookkeeping; a flush empties the FIFO, a stall freezes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy_i) begin
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: NUM_SRC producers share NUM_LANE registered broadcast lanes.
// Each cycle up to NUM_LANE non-empty producer FIFOs are granted in round-robin order.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_LANE   = 2,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int TAG_W      = CDB_TAG_W,
  parameter int FIFO_DEPTH = 2,
  localparam int IDX_W     = idx_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_LANE-1:0]       cdb_valid,
  output logic [NUM_LANE*TAG_W-1:0] cdb_tag,
  output logic [NUM_LANE*DATA_W-1:0] cdb_data,
  output logic [NUM_LANE*IDX_W-1:0] cdb_src,
  output logic                      overflow
);

  localparam int ENTRY_W = TAG_W + DATA_W;

  logic [NUM_SRC-1:0]         fifo_full;
  logic [NUM_SRC-1:0]         fifo_empty;
  logic [ENTRY_W-1:0]         fifo_head [NUM_SRC];
  logic [NUM_SRC-1:0]         grant;

  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_LANE-1:0]        cdb_valid_q, cdb_valid_d;
  logic [NUM_LANE*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [NUM_LANE*DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [NUM_LANE*IDX_W-1:0]  cdb_src_q, cdb_src_d;
  logic                       overflow_q;

  // One private FIFO per producer; the head of each is what the arbiter sees.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .rdy_i   (rdy),
      .flush_i (flush),
      .push_i  (src_valid[i]),
      .pop_i   (grant[i]),
      .wdata_i ({src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]}),
      .rdata_o (fifo_head[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  // Readiness comes only from registered occupancy, so a pop this cycle does not open a slot.
  assign src_ready = ~fifo_full;

  // Scan producers from the round-robin pointer, handing the k-th non-empty one to lane k.
  always_comb begin
    int n;
    int s;
    grant       = '0;
    cdb_valid_d = '0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    cdb_src_d   = '0;
    rr_ptr_d    = rr_ptr_q;
    n           = 0;
    s           = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = int'(rr_ptr_q) + j;
      if (s >= NUM_SRC) begin
        s = s - NUM_SRC;
      end
      if (!fifo_empty[s] && (n < NUM_LANE)) begin
        grant[s]                        = 1'b1;
        cdb_valid_d[n]                  = 1'b1;
        cdb_tag_d[n*TAG_W +: TAG_W]     = fifo_head[s][ENTRY_W-1 -: TAG_W];
        cdb_data_d[n*DATA_W +: DATA_W]  = fifo_head[s][DATA_W-1:0];
        cdb_src_d[n*IDX_W +: IDX_W]     = IDX_W'(s);
        rr_ptr_d                        = (s == NUM_SRC - 1) ? '0 : IDX_W'(s + 1);
        n                               = n + 1;
      end
    end
  end

  // Lane registers and round-robin pointer; a flush kills outgoing results and restarts the scan at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        cdb_valid_q <= '0;
        cdb_tag_q   <= '0;
        cdb_data_q  <= '0;
        cdb_src_q   <= '0;
        rr_ptr_q    <= '0;
      end else begin
        cdb_valid_q <= cdb_valid_d;
        cdb_tag_q   <= cdb_tag_d;
        cdb_data_q  <= cdb_data_d;
        cdb_src_q   <= cdb_src_d;
        rr_ptr_q    <= rr_ptr_d;
      end
    end
  end

  // Sticky record of any result dropped because its producer FIFO was full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (rdy && |(src_valid & fifo_full)) begin
      overflow_q <= 1'b1;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based reference model feeds a scoreboard
// that a separate monitor drains whenever the lanes present new results.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NSRC  = 4;
  localparam int NLANE = 2;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 2;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic                  flush;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC*TW-1:0]    src_tag;
  logic [NSRC*DW-1:0]    src_data;
  logic [NSRC-1:0]       src_ready;
  logic [NLANE-1:0]      cdb_valid;
  logic [NLANE*TW-1:0]   cdb_tag;
  logic [NLANE*DW-1:0]   cdb_data;
  logic [NLANE*IW-1:0]   cdb_src;
  logic                  overflow;

  int errors = 0;
  int checks = 0;

  cdb_arbiter #(
    .NUM_SRC    (NSRC),
    .NUM_LANE   (NLANE),
    .DATA_W     (DW),
    .TAG_W      (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: one result queue per producer plus the scan start.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } item_t;

  typedef struct {
    int        lane;
    int        src;
    cdb_lane_t res;
  } exp_t;

  item_t           fq [NSRC][$];
  exp_t            expQ [$];
  int              rrPtr = 0;
  logic [NLANE-1:0] expMask = '0;
  logic            expOvf = 1'b0;
  bit              newOut = 1'b0;
  logic [TW-1:0]   holdTag [NLANE];
  logic [DW-1:0]   holdData [NLANE];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NSRC-1:0] modelReady();
    logic [NSRC-1:0] r;
    for (int i = 0; i < NSRC; i++) r[i] = (fq[i].size() < DEPTH);
    return r;
  endfunction

  // Behavioural model: producers are queues, the lanes take the first NLANE
  // non-empty queues met when walking around the ring from rrPtr.
  always @(posedge clk or negedge rst) begin : model
    logic [NSRC-1:0] ready;
    int   order [$];
    int   winners [$];
    item_t it;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) fq[i].delete();
      expQ.delete();
      rrPtr   = 0;
      expMask = '0;
      expOvf  = 1'b0;
      newOut  = 1'b0;
    end else if (rdy) begin
      ready = modelReady();
      if (|(src_valid & ~ready)) expOvf = 1'b1;
      if (flush) begin
        for (int i = 0; i < NSRC; i++) fq[i].delete();
        rrPtr   = 0;
        expMask = '0;
      end else begin
        order.delete();
        winners.delete();
        for (int j = 0; j < NSRC; j++) order.push_back((rrPtr + j) % NSRC);
        foreach (order[j]) if (fq[order[j]].size() > 0) winners.push_back(order[j]);
        while (winners.size() > NLANE) void'(winners.pop_back());
        expMask = '0;
        foreach (winners[k]) begin
          it          = fq[winners[k]].pop_front();
          e.lane      = k;
          e.src       = winners[k];
          e.res.valid = 1'b1;
          e.res.tag   = it.tag;
          e.res.data  = it.data;
          expQ.push_back(e);
          expMask[k]  = 1'b1;
        end
        if (winners.size() > 0) rrPtr = (winners[winners.size()-1] + 1) % NSRC;
        for (int i = 0; i < NSRC; i++) begin
          if (src_valid[i] && ready[i]) begin
            it.tag  = src_tag[i*TW +: TW];
            it.data = src_data[i*DW +: DW];
            fq[i].push_back(it);
          end
        end
      end
      newOut = 1'b1;
    end else begin
      newOut = 1'b0;
    end
  end

  // Monitor: on the falling edge, compare status against the model and drain the scoreboard for fresh lanes.
  always @(negedge clk) begin : monitor
    exp_t e;
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(expMask));
    checkOutput("src_ready", 64'(src_ready), 64'(modelReady()));
    checkOutput("overflow", 64'(overflow), 64'(expOvf));
    for (int k = 0; k < NLANE; k++) begin
      if (cdb_valid[k]) begin
        if (newOut) begin
          if (expQ.size() == 0) begin
            checkOutput("lane_unexpected", 64'(k + 1), 64'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("lane_index", 64'(k), 64'(e.lane));
            checkOutput("lane_tag", 64'(cdb_tag[k*TW +: TW]), 64'(e.res.tag));
            checkOutput("lane_data", 64'(cdb_data[k*DW +: DW]), 64'(e.res.data));
            checkOutput("lane_src", 64'(cdb_src[k*IW +: IW]), 64'(e.src));
            holdTag[k]  = e.res.tag;
            holdData[k] = e.res.data;
          end
        end else begin
          checkOutput("hold_tag", 64'(cdb_tag[k*TW +: TW]), 64'(holdTag[k]));
          checkOutput("hold_data", 64'(cdb_data[k*DW +: DW]), 64'(holdData[k]));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NSRC-1:0] v, input logic [NSRC*TW-1:0] t,
                               input logic [NSRC*DW-1:0] d, input logic r, input logic f);
    src_valid = v;
    src_tag   = t;
    src_data  = d;
    rdy       = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic doFlush();
    applyStimulus('0, '0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [NSRC*TW-1:0] t;
    logic [NSRC*DW-1:0] d;
    rst = 1'b1;
    src_valid = '0; src_tag = '0; src_data = '0; rdy = 1'b1; flush = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'(0));
    checkOutput("reset_src_ready", 64'(src_ready), 64'hF);
    checkOutput("reset_overflow", 64'(overflow), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Single push from src0.
    t = '0; d = '0; t[3:0] = 4'd3; d[31:0] = 32'hDEAD_BEEF;
    applyStimulus(4'b0001, t, d, 1'b1, 1'b0);
    idle(1);
    checkOutput("single_valid", 64'(cdb_valid), 64'b01);
    checkOutput("single_tag", 64'(cdb_tag[3:0]), 64'd3);
    checkOutput("single_data", 64'(cdb_data[31:0]), 64'hDEAD_BEEF);
    checkOutput("single_src", 64'(cdb_src[1:0]), 64'd0);
    idle(1);
    checkOutput("single_after", 64'(cdb_valid), 64'b00);

    // Round-robin fairness with all four producers pushing at once.
    doFlush();
    t = {4'd4, 4'd3, 4'd2, 4'd1};
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    applyStimulus(4'b1111, t, d, 1'b1, 1'b0);
    idle(1);
    checkOutput("rr_first_src", 64'(cdb_src), 64'({2'd1, 2'd0}));
    idle(1);
    checkOutput("rr_second_src", 64'(cdb_src), 64'({2'd3, 2'd2}));
    applyStimulus(4'b0011, {4'd0, 4'd0, 4'd8, 4'd7}, '0, 1'b1, 1'b0);
    idle(1);
    checkOutput("rr_wrap_src", 64'(cdb_src), 64'({2'd1, 2'd0}));

    // Full FIFO on src2 while src0/src1 keep the lanes busy, then an overflowing push.
    doFlush(); idle(1);
    for (int c = 0; c < 3; c++) begin
      t = {4'd0, 4'(c + 8), 4'(c + 4), 4'(c)};
      d = {32'h0, 32'(c + 200), 32'(c + 100), 32'(c)};
      applyStimulus(4'b0111, t, d, 1'b1, 1'b0);
      if (c == 1) checkOutput("full_src2_ready", 64'(src_ready[2]), 64'd0);
    end
    checkOutput("overflow_set", 64'(overflow), 64'd1);
    idle(4);

    // Flush with results queued and lanes active; the concurrent src1 push is lost.
    doFlush(); idle(1);
    applyStimulus(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, '0, 1'b1, 1'b0);
    applyStimulus(4'b0010, {4'd0, 4'd0, 4'd9, 4'd0}, '0, 1'b1, 1'b0);
    applyStimulus(4'b0010, {4'd0, 4'd0, 4'd10, 4'd0}, '0, 1'b1, 1'b1);
    checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
    checkOutput("flush_ready", 64'(src_ready), 64'hF);
    idle(3);

    // rdy stall with tags 5 and 6 on the lanes while src0 keeps trying to push.
    doFlush(); idle(1);
    applyStimulus(4'b0011, {4'd0, 4'd0, 4'd6, 4'd5}, {32'h0, 32'h0, 32'h66, 32'h55}, 1'b1, 1'b0);
    idle(1);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd12}, '0, 1'b0, 1'b0);
    checkOutput("stall_tags", 64'(cdb_tag), 64'({4'd6, 4'd5}));
    idle(3);

    // Randomised traffic including stalls and occasional flushes.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        t[i*TW +: TW] = TW'($urandom);
        d[i*DW +: DW] = $urandom;
      end
      applyStimulus(NSRC'($urandom), t, d, ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0));
    end

    // Reset in the middle of traffic.
    applyStimulus(4'b1111, t, d, 1'b1, 1'b0);
    src_valid = '0;
    rst = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(cdb_valid), 64'd0);
    checkOutput("midreset_ready", 64'(src_ready), 64'hF);
    checkOutput("midreset_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        t[i*TW +: TW] = TW'($urandom);
        d[i*DW +: DW] = $urandom;
      end
      applyStimulus(NSRC'($urandom), t, d, ($urandom_range(0, 5) != 0), 1'b0);
    end
    idle(8);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter. Replaces the fixed two-slot CDB (one ALU slot, one load/store slot) with N producers sharing M broadcast lanes.
- Each producer (ALU, LSB, future mul/div, branch unit) pushes {tag, data} into a private shallow FIFO.
- Every cycle the block grants up to NUM_LANE non-empty FIFOs in round-robin order and drives the registered result lanes.
- RS, LSB, ROB and branch predictor snoop those lanes.

Parameters:
- NUM_SRC, 4, number of producer channels (2..8)
- NUM_LANE, 2, number of broadcast lanes (1..NUM_SRC)
- DATA_W, 32, result data width
- TAG_W, 4, ROB tag width
- FIFO_DEPTH, 2, entries per producer FIFO (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; low freezes all state and outputs
- flush  in  1  misprediction flush; clears all queued and outgoing results
- src_valid  in  NUM_SRC  producer i presents a result this cycle
- src_tag  in  NUM_SRC*TAG_W  producer i tag, slice [i*TAG_W +: TAG_W]
- src_data  in  NUM_SRC*DATA_W  producer i data, slice [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  producer i FIFO has space
- cdb_valid  out  NUM_LANE  lane k carries a result
- cdb_tag  out  NUM_LANE*TAG_W  lane k tag
- cdb_data  out  NUM_LANE*DATA_W  lane k data
- cdb_src  out  NUM_LANE*$clog2(NUM_SRC)  lane k originating producer index
- overflow  out  1  sticky: a push was attempted while src_ready was low

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFOs empty; round-robin pointer = 0
  - cdb_valid, cdb_tag, cdb_data, cdb_src = 0
  - src_ready = all ones; overflow = 0
- rdy low: no push, no pop, pointer held, cdb_* outputs held unchanged, overflow held. src_valid is ignored, with no overflow set.
- src_ready[i] = (count[i] != FIFO_DEPTH). It depends on registered count only; there is no pop look-through.
- Push: src_valid[i] & src_ready[i] & rdy & !flush enqueues {tag, data}.
- Overflow: src_valid[i] & !src_ready[i] & rdy drops the result and sets overflow. Overflow is cleared only by reset.
- Arbitration (combinational on registered FIFO state):
  - scan sources starting at pointer p, wrapping modulo NUM_SRC
  - grant the first up to NUM_LANE non-empty FIFOs
  - the k-th grant in scan order goes to lane k; unused lanes get valid 0
- Pop and output: each granted FIFO pops its head. At the same edge the lane registers load {1, tag, data, index}; ungranted lanes load valid 0. Each lane is valid exactly one cycle per result.
- Latency: a push into an empty FIFO at edge t appears on cdb at edge t+1 if granted. Minimum 1 cycle in the FIFO plus the registered lane.
- Pointer update: if any grant occurs, p <= (index of last grant + 1) mod NUM_SRC; otherwise p is unchanged. This guarantees every non-empty source is served within ceil(NUM_SRC/NUM_LANE) granting cycles.
- Same-cycle push and pop on one FIFO:
  - allowed; count unchanged
  - legal even when the FIFO is full, but src_ready is still low that cycle, so no push occurs
- Wrap-around: read/write pointers are $clog2(FIFO_DEPTH) bits with an explicit count register; no pointer-equality ambiguity.
- flush (with rdy high):
  - all FIFOs emptied; pointer reset to 0
  - all cdb_valid <= 0 at that edge
  - same-cycle pushes discarded; overflow unaffected
- flush with rdy low: ignored, as with all other activity.
- Tags are opaque; there is no duplicate-tag checking.

Decomposition:
- Shared package cdb_pkg:
  - default TAG_W/DATA_W constants
  - a lane struct typedef {valid, tag, data}
  - clog2-based index-width localparam helper
- One natural sub-module: cdb_src_fifo (parametrised DATA_W+TAG_W wide, FIFO_DEPTH deep, push/pop/flush/rdy, count-based full/empty), instantiated NUM_SRC times via generate.
- Round-robin multi-grant logic stays in cdb_arbiter.

Test Plan:
- Reset, default params:
  - Stimulus: rst low mid-traffic, then release; src_valid=4'b0000.
  - Required response: cdb_valid=2'b00, src_ready=4'b1111, overflow=0 immediately on rst low.
- Single push:
  - Stimulus: src0 pushes tag 3, data 0xDEAD_BEEF at edge t.
  - Required response: edge t+1 shows lane0 valid, tag 3, data 0xDEADBEEF, src 0; lane1 invalid; edge t+2 shows both lanes invalid.
- Round-robin fairness:
  - Stimulus: all four sources push one result each in the same cycle, with p=0.
  - Required response: cycle 1 grants src0 on lane0 and src1 on lane1; cycle 2 grants src2 and src3; p returns to 0.
- Full FIFO and overflow, FIFO_DEPTH=2:
  - Stimulus: src2 pushes 2 results while only higher-priority traffic is present, so src2 is not drained; a third push is attempted.
  - Required response: src_ready[2]=0 after the second push; the third push is dropped and overflow=1.
- Flush:
  - Stimulus: 3 results queued and lanes valid; assert flush for 1 cycle while src1 pushes.
  - Required response: next cycle cdb_valid=0 and all FIFOs empty; the src1 push is lost; no further outputs.
- rdy stall:
  - Stimulus: lanes valid with tags 5 and 6; rdy low for 3 cycles with pushes on src0.
  - Required response: outputs hold tags 5 and 6 unchanged; no enqueue occurs; after rdy rises, the sequence resumes as if there had been no gap.
